// File: rtl/cnn1d_pkg.sv
// Shared constants for the 1D-CNN datapath.
//   DATA_WIDTH : width of a datapath sample.
package cnn1d_pkg;

   localparam int unsigned DATA_WIDTH = 16;

endpackage

// File: rtl/pow_arbiter.sv
// Round-robin arbiter sharing one pow unit between NUM_REQ requesters.
// Each issued operand pushes the requester index into a tag FIFO. pow returns
// results in issue order, so the FIFO head routes each result back to its owner.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid_in    : per-requester operand valid
//   req_data_in     : per-requester operand
//   req_ready_in    : per-requester accept (one-hot or zero)
//   pow_valid_in    : operand valid towards pow
//   pow_data_in     : operand towards pow
//   pow_ready_in    : pow accepts operand
//   pow_valid_out   : pow result valid
//   pow_data_out    : pow result
//   pow_ready_out   : arbiter accepts pow result
//   rsp_valid_out   : per-requester result valid (one-hot or zero)
//   rsp_data_out    : result, shared by all requesters
//   rsp_ready_out   : per-requester result accept
//   inflight        : tag FIFO occupancy
//   tag_err         : sticky, a result arrived with no tag outstanding
module pow_arbiter
   import cnn1d_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned TAG_DEPTH = 8,
   localparam int unsigned TAG_W    = $clog2(NUM_REQ),
   localparam int unsigned PTR_W    = $clog2(TAG_DEPTH),
   localparam int unsigned CNT_W    = PTR_W + 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_REQ-1:0]                  req_valid_in,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_in,
   output logic [NUM_REQ-1:0]                  req_ready_in,
   output logic                                pow_valid_in,
   output logic [DATA_WIDTH-1:0]               pow_data_in,
   input  logic                                pow_ready_in,
   input  logic                                pow_valid_out,
   input  logic [DATA_WIDTH-1:0]               pow_data_out,
   output logic                                pow_ready_out,
   output logic [NUM_REQ-1:0]                  rsp_valid_out,
   output logic [DATA_WIDTH-1:0]               rsp_data_out,
   input  logic [NUM_REQ-1:0]                  rsp_ready_out,
   output logic [CNT_W-1:0]                    inflight,
   output logic                                tag_err
);

   logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [TAG_W-1:0] grant, head, sel;
   logic [TAG_W-1:0] tag_mem_q [TAG_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             tag_err_q;
   logic             fifo_full, fifo_empty, issue, pop;

   // Full is judged on the registered count, so a same-cycle pop never frees a slot.
   assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
   assign fifo_empty = (count_q == '0);

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      logic        found;
      int unsigned idx;
      grant = rr_ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(rr_ptr_q) + i) % NUM_REQ;
         if (!found && req_valid_in[idx]) begin
            grant = TAG_W'(idx);
            found = 1'b1;
         end
      end
   end

   assign issue = (|req_valid_in) & pow_ready_in & ~fifo_full & ~rst;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) begin
         rr_ptr_d = (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);
      end
   end

   // Issue side.
   always_comb begin
      req_ready_in = '0;
      if (issue) begin
         req_ready_in[grant] = 1'b1;
      end
      pow_valid_in = issue;
      sel          = issue ? grant : rr_ptr_q;
      pow_data_in  = req_data_in[sel];
   end

   // Response side. With no tag outstanding the result is drained and dropped.
   always_comb begin
      head          = tag_mem_q[rd_ptr_q];
      rsp_valid_out = '0;
      if (pow_valid_out && !fifo_empty && !rst) begin
         rsp_valid_out[head] = 1'b1;
      end
      rsp_data_out  = pow_data_out;
      pow_ready_out = ~rst & (fifo_empty | rsp_ready_out[head]);
   end

   assign pop = pow_valid_out & pow_ready_out & ~fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         tag_err_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (issue) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (issue && !pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (pop && !issue) begin
            count_q <= count_q - CNT_W'(1);
         end
         if (pow_valid_out && fifo_empty) begin
            tag_err_q <= 1'b1;
         end
      end
   end

   // Tag storage needs no reset: entries are only read while the count covers them.
   always_ff @(posedge clk) begin
      if (issue) begin
         tag_mem_q[wr_ptr_q] <= grant;
      end
   end

   assign inflight = count_q;
   assign tag_err  = tag_err_q;

endmodule

// File: tb/tb_pow_arbiter.sv
// Directed bench for pow_arbiter with NUM_REQ=4, TAG_DEPTH=4 and a pow stub
// (latency 3, result = operand + 1).
module tb_pow_arbiter;
   import cnn1d_pkg::*;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = DATA_WIDTH;
   localparam int unsigned CW    = $clog2(DEPTH) + 1;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic [NREQ-1:0]          req_valid;
   logic [NREQ-1:0][DW-1:0]  req_data;
   logic [NREQ-1:0]          req_ready;
   logic                     pow_valid_in, pow_ready_in, pow_valid_out, pow_ready_out;
   logic [DW-1:0]            pow_data_in, pow_data_out, rsp_data;
   logic [NREQ-1:0]          rsp_valid, rsp_ready;
   logic [CW-1:0]            inflight;
   logic                     tag_err;

   always #5 clk = ~clk;

   pow_arbiter #(
      .NUM_REQ   (NREQ),
      .TAG_DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid_in  (req_valid),
      .req_data_in   (req_data),
      .req_ready_in  (req_ready),
      .pow_valid_in  (pow_valid_in),
      .pow_data_in   (pow_data_in),
      .pow_ready_in  (pow_ready_in),
      .pow_valid_out (pow_valid_out),
      .pow_data_out  (pow_data_out),
      .pow_ready_out (pow_ready_out),
      .rsp_valid_out (rsp_valid),
      .rsp_data_out  (rsp_data),
      .rsp_ready_out (rsp_ready),
      .inflight      (inflight),
      .tag_err       (tag_err)
   );

   // pow stub: in-order queue, each entry visible 3 cycles after acceptance.
   // stub_all models a deeply buffered pow that always accepts.
   logic [DW-1:0] sq_d [16];
   int unsigned   sq_t [16];
   logic [3:0]    sq_wr, sq_rd;
   int unsigned   stub_cyc;
   logic          stub_all, force_v, stub_valid;
   logic [DW-1:0] force_d;

   assign stub_valid    = (sq_wr != sq_rd) && (stub_cyc >= sq_t[sq_rd] + 3);
   assign pow_ready_in  = stub_all | ~stub_valid | pow_ready_out;
   assign pow_valid_out = stub_valid | force_v;
   assign pow_data_out  = force_v ? force_d : sq_d[sq_rd];

   always_ff @(posedge clk) begin
      if (rst) begin
         sq_wr    <= '0;
         sq_rd    <= '0;
         stub_cyc <= 0;
      end else begin
         stub_cyc <= stub_cyc + 1;
         if (pow_valid_in && pow_ready_in) begin
            sq_d[sq_wr] <= pow_data_in + DW'(1);
            sq_t[sq_wr] <= stub_cyc;
            sq_wr       <= sq_wr + 4'd1;
         end
         if (stub_valid && pow_ready_out) begin
            sq_rd <= sq_rd + 4'd1;
         end
      end
   end

   int quota [NREQ];
   int sent  [NREQ];
   int base  [NREQ];
   int stride;
   int iss_log[$], iss_cyc[$], rsp_tag[$], rsp_dat[$], rsp_cyc[$], infl_log[$];
   int cyc, infl_max;
   int n_checks = 0;
   int n_fail   = 0;

   logic [NREQ-1:0] smp_req_ready, smp_rsp_valid;
   logic            smp_pow_valid_in, smp_pow_ready_out, smp_tag_err;
   logic [CW-1:0]   smp_inflight;
   logic [DW-1:0]   smp_rsp_data;

   function automatic int oh2idx(input logic [NREQ-1:0] v);
      int r = -1;
      for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = (sent[i] < quota[i]);
         req_data[i]  = DW'(base[i] + stride * sent[i]);
      end
   endtask

   task automatic clear_logs();
      iss_log.delete(); iss_cyc.delete(); rsp_tag.delete();
      rsp_dat.delete(); rsp_cyc.delete(); infl_log.delete();
      cyc = 0;
      infl_max = 0;
   endtask

   // One clock: sample at negedge, then advance requesters after posedge.
   task automatic cycle();
      @(negedge clk);
      smp_req_ready     = req_ready;
      smp_rsp_valid     = rsp_valid;
      smp_pow_valid_in  = pow_valid_in;
      smp_pow_ready_out = pow_ready_out;
      smp_tag_err       = tag_err;
      smp_inflight      = inflight;
      smp_rsp_data      = rsp_data;
      if (pow_valid_in) begin
         iss_log.push_back(oh2idx(req_ready));
         iss_cyc.push_back(cyc);
      end
      for (int i = 0; i < NREQ; i++) begin
         if (rsp_valid[i] && rsp_ready[i]) begin
            rsp_tag.push_back(i);
            rsp_dat.push_back(int'(rsp_data));
            rsp_cyc.push_back(cyc);
         end
      end
      infl_log.push_back(int'(inflight));
      if (int'(inflight) > infl_max) infl_max = int'(inflight);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < NREQ; i++) if (smp_req_ready[i] && req_valid[i]) sent[i]++;
      drive_reqs();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      force_v   = 1'b0;
      force_d   = '0;
      stub_all  = 1'b0;
      rsp_ready = '1;
      stride    = 1;
      for (int i = 0; i < NREQ; i++) begin
         quota[i] = 0;
         sent[i]  = 0;
         base[i]  = i * 256;
      end
      drive_reqs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      force_v   = 1'b1;
      force_d   = 16'h0055;
      stub_all  = 1'b0;
      rsp_ready = '1;
      stride    = 1;
      for (int i = 0; i < NREQ; i++) begin
         quota[i] = 1;
         sent[i]  = 0;
         base[i]  = i * 256;
      end
      drive_reqs();
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
      end
      n_checks++;
      if (pow_valid_in !== 1'b0) begin
         n_fail++; $display("FAIL reset_pow_valid_in: got %b want 0", pow_valid_in);
      end
      n_checks++;
      if (pow_ready_out !== 1'b0) begin
         n_fail++; $display("FAIL reset_pow_ready_out: got %b want 0", pow_ready_out);
      end
      n_checks++;
      if (rsp_valid !== 4'b0000) begin
         n_fail++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid);
      end
      @(posedge clk);
      #1;
      rst     = 1'b0;
      force_v = 1'b0;
      for (int i = 0; i < NREQ; i++) quota[i] = 0;
      drive_reqs();
      @(negedge clk);
      n_checks++;
      if (inflight !== 3'd0) begin
         n_fail++; $display("FAIL reset_inflight: got %0d want 0", inflight);
      end
      n_checks++;
      if (tag_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_tag_err: got %b want 0", tag_err);
      end
      n_checks++;
      if (pow_ready_out !== 1'b1) begin
         n_fail++; $display("FAIL idle_pow_ready_out: got %b want 1", pow_ready_out);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single();
      do_reset();
      quota[2] = 3;
      base[2]  = 10;
      stride   = 10;
      drive_reqs();
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (smp_rsp_valid != 4'b0000) begin
            n_checks++;
            if (smp_rsp_valid !== 4'b0100) begin
               n_fail++; $display("FAIL single_rsp_vec: got %b want 0100", smp_rsp_valid);
            end
         end
      end
      n_checks++;
      if (iss_log.size() != 3 || rsp_tag.size() != 3) begin
         n_fail++;
         $display("FAIL single_counts: issues %0d rsps %0d want 3 3", iss_log.size(),
                  rsp_tag.size());
      end
      for (int j = 0; j < 3; j++) begin
         n_checks++;
         if ((j < iss_log.size() ? iss_log[j] : -1) != 2) begin
            n_fail++; $display("FAIL single_grant[%0d]: want requester 2", j);
         end
         n_checks++;
         if ((j < rsp_dat.size() ? rsp_dat[j] : -1) != 10 * (j + 1) + 1) begin
            n_fail++;
            $display("FAIL single_data[%0d]: got %0d want %0d", j,
                     (j < rsp_dat.size() ? rsp_dat[j] : -1), 10 * (j + 1) + 1);
         end
         n_checks++;
         if ((j < rsp_cyc.size() ? rsp_cyc[j] : -1) !=
             (iss_cyc.size() > 0 ? iss_cyc[0] : 0) + 3 + j) begin
            n_fail++; $display("FAIL single_latency[%0d]: result not at issue+%0d", j, 3 + j);
         end
      end
      n_checks++;
      if (infl_max != 3) begin
         n_fail++; $display("FAIL single_inflight_peak: got %0d want 3", infl_max);
      end
   endtask

   task automatic test_fairness();
      int nth [NREQ];
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         quota[i] = 3;
         nth[i]   = 0;
      end
      drive_reqs();
      repeat (20) cycle();
      n_checks++;
      if (iss_log.size() != 12 || rsp_tag.size() != 12) begin
         n_fail++;
         $display("FAIL fair_counts: issues %0d rsps %0d want 12 12", iss_log.size(),
                  rsp_tag.size());
      end
      for (int j = 0; j < 12; j++) begin
         n_checks++;
         if ((j < iss_log.size() ? iss_log[j] : -1) != j % 4) begin
            n_fail++;
            $display("FAIL fair_grant[%0d]: got %0d want %0d", j,
                     (j < iss_log.size() ? iss_log[j] : -1), j % 4);
         end
      end
      for (int j = 0; j < rsp_tag.size(); j++) begin
         n_checks++;
         if (rsp_dat[j] != rsp_tag[j] * 256 + nth[rsp_tag[j]] + 1) begin
            n_fail++;
            $display("FAIL fair_route[%0d]: req %0d got %0d want %0d", j, rsp_tag[j],
                     rsp_dat[j], rsp_tag[j] * 256 + nth[rsp_tag[j]] + 1);
         end
         nth[rsp_tag[j]]++;
      end
   endtask

   task automatic test_full();
      int nth [NREQ];
      do_reset();
      stub_all  = 1'b1;
      rsp_ready = 4'b0000;
      for (int i = 0; i < NREQ; i++) begin
         quota[i] = 3;
         nth[i]   = 0;
      end
      drive_reqs();
      repeat (6) cycle();
      n_checks++;
      if (iss_log.size() != 4) begin
         n_fail++; $display("FAIL full_issue_count: got %0d want 4", iss_log.size());
      end
      n_checks++;
      if (smp_req_ready !== 4'b0000 || smp_inflight !== 3'd4) begin
         n_fail++;
         $display("FAIL full_stall: ready %b inflight %0d want 0000 4", smp_req_ready,
                  smp_inflight);
      end
      n_checks++;
      if (smp_pow_ready_out !== 1'b0) begin
         n_fail++; $display("FAIL full_backpressure: got %b want 0", smp_pow_ready_out);
      end
      rsp_ready = 4'b0001;
      cycle();
      n_checks++;
      if (smp_req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL full_pop_no_push: got %b want 0000", smp_req_ready);
      end
      n_checks++;
      if (rsp_tag.size() != 1 || smp_rsp_data !== 16'd1) begin
         n_fail++;
         $display("FAIL full_first_pop: rsps %0d data %0d want 1 1", rsp_tag.size(),
                  smp_rsp_data);
      end
      cycle();
      n_checks++;
      if (smp_req_ready !== 4'b0001 || smp_pow_valid_in !== 1'b1) begin
         n_fail++;
         $display("FAIL full_resume: ready %b valid %b want 0001 1", smp_req_ready,
                  smp_pow_valid_in);
      end
      n_checks++;
      if (rsp_tag.size() != 1) begin
         n_fail++; $display("FAIL full_hol_block: rsps %0d want 1", rsp_tag.size());
      end
      cycle();
      n_checks++;
      if (smp_req_ready !== 4'b0000 || smp_inflight !== 3'd4) begin
         n_fail++;
         $display("FAIL full_refull: ready %b inflight %0d want 0000 4", smp_req_ready,
                  smp_inflight);
      end
      rsp_ready = 4'b1111;
      repeat (25) cycle();
      n_checks++;
      if (iss_log.size() != 12 || rsp_tag.size() != 12 || smp_inflight !== 3'd0) begin
         n_fail++;
         $display("FAIL full_drain: issues %0d rsps %0d inflight %0d want 12 12 0",
                  iss_log.size(), rsp_tag.size(), smp_inflight);
      end
      for (int j = 0; j < rsp_tag.size(); j++) begin
         n_checks++;
         if (rsp_dat[j] != rsp_tag[j] * 256 + nth[rsp_tag[j]] + 1) begin
            n_fail++;
            $display("FAIL full_route[%0d]: req %0d got %0d want %0d", j, rsp_tag[j],
                     rsp_dat[j], rsp_tag[j] * 256 + nth[rsp_tag[j]] + 1);
         end
         nth[rsp_tag[j]]++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < NREQ; i++) quota[i] = 5;
      drive_reqs();
      repeat (26) cycle();
      n_checks++;
      if (iss_log.size() != 20 || rsp_tag.size() != 20) begin
         n_fail++;
         $display("FAIL b2b_counts: issues %0d rsps %0d want 20 20", iss_log.size(),
                  rsp_tag.size());
      end
      for (int j = 3; j < 20; j++) begin
         n_checks++;
         if ((j < infl_log.size() ? infl_log[j] : -1) != 3) begin
            n_fail++;
            $display("FAIL b2b_inflight[%0d]: got %0d want 3", j,
                     (j < infl_log.size() ? infl_log[j] : -1));
         end
      end
      for (int j = 0; j < 20; j++) begin
         n_checks++;
         if ((j < rsp_tag.size() ? rsp_tag[j] : -1) != j % 4 ||
             (j < rsp_dat.size() ? rsp_dat[j] : -1) != (j % 4) * 256 + j / 4 + 1) begin
            n_fail++;
            $display("FAIL b2b_rsp[%0d]: req %0d data %0d want %0d %0d", j,
                     (j < rsp_tag.size() ? rsp_tag[j] : -1),
                     (j < rsp_dat.size() ? rsp_dat[j] : -1), j % 4, (j % 4) * 256 + j / 4 + 1);
         end
      end
   endtask

   task automatic test_stray();
      do_reset();
      force_v = 1'b1;
      force_d = 16'h00ab;
      cycle();
      n_checks++;
      if (smp_rsp_valid !== 4'b0000 || smp_pow_ready_out !== 1'b1) begin
         n_fail++;
         $display("FAIL stray_drain: rsp %b ready %b want 0000 1", smp_rsp_valid,
                  smp_pow_ready_out);
      end
      n_checks++;
      if (smp_tag_err !== 1'b0 || smp_rsp_data !== 16'h00ab) begin
         n_fail++;
         $display("FAIL stray_same_cycle: err %b data %h want 0 00ab", smp_tag_err,
                  smp_rsp_data);
      end
      force_v = 1'b0;
      cycle();
      n_checks++;
      if (smp_tag_err !== 1'b1) begin
         n_fail++; $display("FAIL stray_tag_err: got %b want 1", smp_tag_err);
      end
      cycle();
      n_checks++;
      if (smp_tag_err !== 1'b1 || smp_inflight !== 3'd0) begin
         n_fail++;
         $display("FAIL stray_sticky: err %b inflight %0d want 1 0", smp_tag_err,
                  smp_inflight);
      end
   endtask

   // Runs straight after test_stray so tag_err is set going in.
   task automatic test_reset_mid();
      for (int i = 0; i < NREQ; i++) begin
         quota[i] = 0;
         sent[i]  = 0;
      end
      quota[1] = 3;
      drive_reqs();
      clear_logs();
      repeat (3) cycle();
      rst = 1'b1;
      cycle();
      n_checks++;
      if (smp_inflight !== 3'd3 || iss_log.size() != 3) begin
         n_fail++;
         $display("FAIL mid_setup: inflight %0d issues %0d want 3 3", smp_inflight,
                  iss_log.size());
      end
      n_checks++;
      if (smp_req_ready !== 4'b0000 || smp_pow_valid_in !== 1'b0 ||
          smp_rsp_valid !== 4'b0000 || smp_pow_ready_out !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_gating: rdy %b pv %b rsp %b pr %b want all 0", smp_req_ready,
                  smp_pow_valid_in, smp_rsp_valid, smp_pow_ready_out);
      end
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) quota[i] = sent[i] + 1;
      drive_reqs();
      cycle();
      n_checks++;
      if (smp_inflight !== 3'd0 || smp_tag_err !== 1'b0 || smp_rsp_valid !== 4'b0000) begin
         n_fail++;
         $display("FAIL mid_cleared: inflight %0d err %b rsp %b want 0 0 0000", smp_inflight,
                  smp_tag_err, smp_rsp_valid);
      end
      n_checks++;
      if (smp_req_ready !== 4'b0001 || smp_pow_valid_in !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_rr_ptr: ready %b want 0001", smp_req_ready);
      end
   endtask

   initial begin
      stub_all  = 1'b0;
      force_v   = 1'b0;
      force_d   = '0;
      rsp_ready = '1;
      req_valid = '0;
      req_data  = '0;
      test_reset();
      test_single();
      test_fairness();
      test_full();
      test_back_to_back();
      test_stray();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
